// File: rtl/bit_serializer.sv
// -----------------------------------------------------------------------------
// bit_serializer
//   Parallel-to-serial converter. A WIDTH-bit word offered on din/din_valid is
//   captured when din_ready is high and shifted out LSB first, one bit per
//   clock, on ser_out/ser_valid. After each word, GAP idle cycles can be
//   inserted. With GAP == 0, a new word may be accepted on the last-bit cycle
//   so consecutive words stream without a bubble.
//
// Parameters
//   WIDTH      bits per word (2..32)
//   GAP        idle cycles after each word (0..15)
//
// Ports
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   din        parallel word to transmit
//   din_valid  din holds a word offered for transmission
//   din_ready  block accepts din on this cycle
//   ser_out    serial data, LSB first (0 when ser_valid is low)
//   ser_valid  ser_out carries a data bit this cycle
//   busy       state is not IDLE
//   done       high during the last bit of a word
// -----------------------------------------------------------------------------
module bit_serializer #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned GAP   = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned     CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);
    localparam logic [3:0]      GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam logic            GAP_EN   = (GAP > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [3:0]       gap_cnt_r;
    logic [3:0]       gap_cnt_nxt_s;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] shift_nxt_s;
    logic             ser_out_r;
    logic             ser_valid_r;
    logic             done_r;
    logic             last_bit_s;
    logic             din_ready_s;
    logic             accept_s;

    // Last-bit detection, handshake and accept qualification.
    always_comb begin
        last_bit_s  = (state_r == ST_SHIFT) && (cnt_r == CNT_LAST);
        // Back-to-back reload on the last bit is only possible without a gap.
        din_ready_s = (state_r == ST_IDLE) || (last_bit_s && !GAP_EN);
        accept_s    = din_valid && din_ready_s;
    end

    // Next-state, bit counter, gap counter and shift register update.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        gap_cnt_nxt_s = gap_cnt_r;
        shift_nxt_s   = shift_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = {CW{1'b0}};
                    shift_nxt_s = din;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (!last_bit_s) begin
                    cnt_nxt_s   = cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    shift_nxt_s = {1'b0, shift_r[WIDTH-1:1]};
                end else if (accept_s) begin
                    state_nxt_s = ST_SHIFT;
                    cnt_nxt_s   = {CW{1'b0}};
                    shift_nxt_s = din;
                end else if (GAP_EN) begin
                    state_nxt_s   = ST_GAP;
                    gap_cnt_nxt_s = 4'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_r == GAP_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + 4'd1;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                cnt_nxt_s     = {CW{1'b0}};
                gap_cnt_nxt_s = 4'd0;
                shift_nxt_s   = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, counters and shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CW{1'b0}};
            gap_cnt_r <= 4'd0;
            shift_r   <= {WIDTH{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_nxt_s;
            gap_cnt_r <= gap_cnt_nxt_s;
            shift_r   <= shift_nxt_s;
        end
    end

    // Serial outputs registered from next-state values, so they always match
    // the registered state without any combinational path from din.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ser_out_r   <= 1'b0;
            ser_valid_r <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            ser_valid_r <= (state_nxt_s == ST_SHIFT);
            ser_out_r   <= (state_nxt_s == ST_SHIFT) && shift_nxt_s[0];
            done_r      <= (state_nxt_s == ST_SHIFT) && (cnt_nxt_s == CNT_LAST);
        end
    end

    assign din_ready = din_ready_s;
    assign ser_out   = ser_out_r;
    assign ser_valid = ser_valid_r;
    assign done      = done_r;
    assign busy      = (state_r != ST_IDLE);

endmodule
